// File: rtl/and_circuit_pkg.sv
// ---------------------------------------------------------------------------
// and_circuit_pkg
// Shared definitions for the 4x2-input + 1x8-input AND circuit and its
// exhaustive pattern checker.
//   PAT_W / RESP_W / ERR_W : pattern, response and error-counter widths
//   chk_state_t            : checker sequencer states
//   and_expected()         : golden 5-bit result for an 8-bit input pattern
// ---------------------------------------------------------------------------
package and_circuit_pkg;

    localparam int PAT_W  = 8;
    localparam int RESP_W = 5;
    // 9 bits so that a count of all 256 patterns failing fits without wrap
    localparam int ERR_W  = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } chk_state_t;

    // Reference result: [3:0] pairwise ANDs, [4] AND of all eight inputs
    function automatic logic [RESP_W-1:0] and_expected(input logic [PAT_W-1:0] pattern);
        logic [RESP_W-1:0] res_s;
        res_s[0] = pattern[1] & pattern[0];
        res_s[1] = pattern[3] & pattern[2];
        res_s[2] = pattern[5] & pattern[4];
        res_s[3] = pattern[7] & pattern[6];
        res_s[4] = &pattern;
        return res_s;
    endfunction

endpackage

// File: rtl/and_pattern_checker_if.sv
// ---------------------------------------------------------------------------
// and_pattern_checker_if
// Control / result bundle of the AND-circuit pattern checker.
//   start, abort       : run control from the controlling side
//   resp_in            : AND circuit results fed back to the checker
//   stim_out           : pattern driven onto the AND circuit inputs
//   busy, done, pass   : run status
//   err_count          : number of mismatching patterns
//   first_err_valid/_pattern : first mismatching pattern record
// Modports: master = controller/test side, slave = checker.
// ---------------------------------------------------------------------------
interface and_pattern_checker_if;
    import and_circuit_pkg::*;

    logic              start;
    logic              abort;
    logic [RESP_W-1:0] resp_in;
    logic [PAT_W-1:0]  stim_out;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ERR_W-1:0]  err_count;
    logic              first_err_valid;
    logic [PAT_W-1:0]  first_err_pattern;

    modport master (
        output start, abort, resp_in,
        input  stim_out, busy, done, pass, err_count, first_err_valid, first_err_pattern
    );

    modport slave (
        input  start, abort, resp_in,
        output stim_out, busy, done, pass, err_count, first_err_valid, first_err_pattern
    );

endinterface

// File: rtl/settle_timer.sv
// ---------------------------------------------------------------------------
// settle_timer
// Loadable down-counter measuring how long a pattern settles before sampling.
//   clk, rst : clock and synchronous active-high reset
//   load     : load load_val (takes priority over en)
//   load_val : number of further cycles to wait after the load cycle
//   en       : count down by one while not yet expired
//   expired  : registered flag, high once the count has reached zero
// ---------------------------------------------------------------------------
module settle_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [CNT_W-1:0] count_r;
    logic             expired_r;

    // Counter and expiry flag; the flag is computed alongside the count so it
    // is valid in the very cycle the count reaches zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r   <= {CNT_W{1'b0}};
            expired_r <= 1'b0;
        end else if (load) begin
            count_r   <= load_val;
            expired_r <= (load_val == {CNT_W{1'b0}});
        end else if (en && (count_r != {CNT_W{1'b0}})) begin
            count_r   <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
            expired_r <= (count_r == {{(CNT_W-1){1'b0}}, 1'b1});
        end else begin
            count_r   <= count_r;
            expired_r <= expired_r;
        end
    end

    assign expired = expired_r;

endmodule

// File: rtl/and_pattern_checker.sv
// ---------------------------------------------------------------------------
// and_pattern_checker
// Exhaustive self-test sequencer for the 4x2-input + 1x8-input AND circuit.
// Walks all 256 patterns, waits SETTLE_CYCLES per pattern, samples the
// circuit response and keeps pass/fail, error count and first failing pattern.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of and_pattern_checker_if (start/abort/resp_in in,
//              stim_out/busy/done/pass/err_count/first_err_* out, all registered)
// Parameter SETTLE_CYCLES (1..15): cycles between driving and sampling.
// ---------------------------------------------------------------------------
module and_pattern_checker
    import and_circuit_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    and_pattern_checker_if.slave   bus
);

    // The timer is loaded on SETTLE entry, which already counts as one cycle
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 32'd1);

    chk_state_t        state_r;
    chk_state_t        state_nx_s;
    logic              timer_load_s;
    logic              timer_en_s;
    logic              timer_expired_s;
    logic              mismatch_s;
    logic              last_pattern_s;

    logic [PAT_W-1:0]  pattern_r;
    logic [PAT_W-1:0]  stim_r;
    logic              busy_r;
    logic              done_r;
    logic              pass_r;
    logic [ERR_W-1:0]  err_count_r;
    logic              first_err_valid_r;
    logic [PAT_W-1:0]  first_err_pattern_r;

    settle_timer #(
        .CNT_W (4)
    ) u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load_s),
        .load_val (SETTLE_LOAD),
        .en       (timer_en_s),
        .expired  (timer_expired_s)
    );

    assign mismatch_s     = (bus.resp_in != and_expected(pattern_r));
    assign last_pattern_s = (pattern_r == 8'hFF);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next state and settle-timer control; abort outranks every busy-state transition
    always_comb begin
        state_nx_s   = state_r;
        timer_load_s = 1'b0;
        timer_en_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_nx_s   = SETTLE;
                    timer_load_s = 1'b1;
                end else begin
                    state_nx_s   = IDLE;
                end
            end
            SETTLE: begin
                if (bus.abort) begin
                    state_nx_s = IDLE;
                end else if (timer_expired_s) begin
                    state_nx_s = SAMPLE;
                end else begin
                    state_nx_s = SETTLE;
                    timer_en_s = 1'b1;
                end
            end
            SAMPLE: begin
                if (bus.abort) begin
                    state_nx_s = IDLE;
                end else if (last_pattern_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s   = SETTLE;
                    timer_load_s = 1'b1;
                end
            end
            DONE: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Pattern register, status outputs and error bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_r           <= 8'h00;
            stim_r              <= 8'h00;
            busy_r              <= 1'b0;
            done_r              <= 1'b0;
            pass_r              <= 1'b0;
            err_count_r         <= 9'd0;
            first_err_valid_r   <= 1'b0;
            first_err_pattern_r <= 8'h00;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    stim_r <= 8'h00;
                    if (bus.start) begin
                        pattern_r           <= 8'h00;
                        busy_r              <= 1'b1;
                        pass_r              <= 1'b0;
                        err_count_r         <= 9'd0;
                        first_err_valid_r   <= 1'b0;
                        first_err_pattern_r <= 8'h00;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                SETTLE: begin
                    done_r <= 1'b0;
                    if (bus.abort) begin
                        busy_r <= 1'b0;
                        stim_r <= 8'h00;
                    end
                end
                SAMPLE: begin
                    done_r <= 1'b0;
                    if (bus.abort) begin
                        busy_r <= 1'b0;
                        stim_r <= 8'h00;
                    end else begin
                        if (mismatch_s) begin
                            err_count_r <= err_count_r + 9'd1;
                            if (!first_err_valid_r) begin
                                first_err_valid_r   <= 1'b1;
                                first_err_pattern_r <= pattern_r;
                            end
                        end
                        // After 0xFF the run ends, so the increment never wraps
                        if (!last_pattern_s) begin
                            pattern_r <= pattern_r + 8'd1;
                            stim_r    <= pattern_r + 8'd1;
                        end
                    end
                end
                DONE: begin
                    // Completion is reported even if abort arrives now
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    stim_r <= 8'h00;
                    pass_r <= (err_count_r == 9'd0);
                end
                default: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    stim_r <= 8'h00;
                end
            endcase
        end
    end

    assign bus.stim_out          = stim_r;
    assign bus.busy              = busy_r;
    assign bus.done              = done_r;
    assign bus.pass              = pass_r;
    assign bus.err_count         = err_count_r;
    assign bus.first_err_valid   = first_err_valid_r;
    assign bus.first_err_pattern = first_err_pattern_r;

endmodule

// File: tb/tb_and_pattern_checker.sv
// ---------------------------------------------------------------------------
// tb_and_pattern_checker
// Two checkers (SETTLE_CYCLES 2 and 1) share start/abort/rst and each face an
// AND circuit model that can be golden, have one result bit stuck, or be a
// two-stage registered pipeline. Expected run results come from a pattern-
// by-pattern reference loop over all 256 inputs.
// ---------------------------------------------------------------------------
module tb_and_pattern_checker;
    import and_circuit_pkg::*;

    localparam int S0     = 2;
    localparam int S1     = 1;
    localparam int PIPE_L = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    and_pattern_checker_if bus0 ();
    and_pattern_checker_if bus1 ();

    and_pattern_checker #(.SETTLE_CYCLES(S0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    and_pattern_checker #(.SETTLE_CYCLES(S1)) dut_s1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int   vectors     = 0;
    int   miscompares = 0;

    // circuit model selection: 0 golden, 1 stuck bit, 2 two-stage pipeline
    int   cur_mode  = 0;
    int   stuck_bit = 0;
    logic stuck_val = 1'b0;

    logic [4:0] pa0 = 5'd0, pb0 = 5'd0, pa1 = 5'd0, pb1 = 5'd0;

    function automatic logic [4:0] model_and(input logic [7:0] p);
        logic [4:0] r;
        for (int i = 0; i < 4; i++) r[i] = p[2*i] & p[2*i+1];
        r[4] = (p == 8'hFF);
        return r;
    endfunction

    function automatic logic [4:0] circuit(input logic [7:0] p, input int m, input int b, input logic v);
        logic [4:0] r;
        r = model_and(p);
        if (m == 1) r[b] = v;
        return r;
    endfunction

    always @(posedge clk) begin
        pa0 <= model_and(bus0.stim_out);
        pb0 <= pa0;
        pa1 <= model_and(bus1.stim_out);
        pb1 <= pa1;
    end

    assign bus0.resp_in = (cur_mode == 2) ? pb0 : circuit(bus0.stim_out, cur_mode, stuck_bit, stuck_val);
    assign bus1.resp_in = (cur_mode == 2) ? pb1 : circuit(bus1.stim_out, cur_mode, stuck_bit, stuck_val);
    assign bus1.start   = bus0.start;
    assign bus1.abort   = bus0.abort;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference outcome of a full run: what the checker sees for each pattern
    function automatic void expect_run(input int s, output int ec, output logic [7:0] fp, output logic fv);
        ec = 0;
        fp = 8'h00;
        fv = 1'b0;
        for (int k = 0; k < 256; k++) begin
            logic [7:0] p;
            logic [7:0] seen;
            logic [4:0] got;
            p = 8'(k);
            if (cur_mode == 2) begin
                // a response slower than the settle window still shows the previous pattern
                seen = (PIPE_L > s && k > 0) ? 8'(k - 1) : p;
                got  = model_and(seen);
            end else begin
                got = circuit(p, cur_mode, stuck_bit, stuck_val);
            end
            if (got != model_and(p)) begin
                ec++;
                if (!fv) begin
                    fv = 1'b1;
                    fp = p;
                end
            end
        end
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
    endtask

    task automatic do_run(input string name, input int extra_start, input bit chk_s1);
        int n;
        int ec0, ec1;
        logic [7:0] fp0, fp1;
        logic fv0, fv1;
        expect_run(S0, ec0, fp0, fv0);
        expect_run(S1, ec1, fp1, fv1);
        pulse_start();
        check_val({name, " busy_rise"}, 32'(bus0.busy), 32'd1);
        check_val({name, " stim_first"}, 32'(bus0.stim_out), 32'd0);
        n = 0;
        while (bus0.done !== 1'b1 && n < 2000) begin
            bus0.start = (n == extra_start);
            @(negedge clk);
            n++;
        end
        bus0.start = 1'b0;
        check_val({name, " done_latency"}, 32'(n), 32'(256 * (S0 + 1) + 1));
        check_val({name, " pass"}, 32'(bus0.pass), 32'(ec0 == 0));
        check_val({name, " err_count"}, 32'(bus0.err_count), 32'(ec0));
        check_val({name, " first_valid"}, 32'(bus0.first_err_valid), 32'(fv0));
        check_val({name, " first_pattern"}, 32'(bus0.first_err_pattern), 32'(fp0));
        @(negedge clk);
        check_val({name, " done_pulse_end"}, 32'(bus0.done), 32'd0);
        check_val({name, " busy_fall"}, 32'(bus0.busy), 32'd0);
        check_val({name, " stim_idle"}, 32'(bus0.stim_out), 32'd0);
        if (chk_s1) begin
            check_val({name, " s1 pass"}, 32'(bus1.pass), 32'(ec1 == 0));
            check_val({name, " s1 err_count"}, 32'(bus1.err_count), 32'(ec1));
            check_val({name, " s1 first_pattern"}, 32'(bus1.first_err_pattern), 32'(fp1));
            check_val({name, " s1 err_nonzero"}, 32'(bus1.err_count != 9'd0), 32'd1);
        end
    endtask

    task automatic do_abort(input int at);
        int n;
        bit seen_done;
        pulse_start();
        n = 0;
        while (n < at - 1) begin
            @(negedge clk);
            n++;
        end
        bus0.abort = 1'b1;
        @(negedge clk);
        bus0.abort = 1'b0;
        check_val("abort busy", 32'(bus0.busy), 32'd0);
        check_val("abort stim", 32'(bus0.stim_out), 32'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 900; i++) begin
            if (bus0.done === 1'b1) seen_done = 1'b1;
            @(negedge clk);
        end
        check_val("abort no_done", 32'(seen_done), 32'd0);
        check_val("abort pass", 32'(bus0.pass), 32'd0);
        check_val("abort err_count", 32'(bus0.err_count), 32'd0);
    endtask

    task automatic do_reset_mid(input int at);
        int n;
        pulse_start();
        n = 0;
        while (n < at - 1) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("rst stim", 32'(bus0.stim_out), 32'd0);
        check_val("rst busy", 32'(bus0.busy), 32'd0);
        check_val("rst done", 32'(bus0.done), 32'd0);
        check_val("rst pass", 32'(bus0.pass), 32'd0);
        check_val("rst err_count", 32'(bus0.err_count), 32'd0);
        check_val("rst first_valid", 32'(bus0.first_err_valid), 32'd0);
        check_val("rst first_pattern", 32'(bus0.first_err_pattern), 32'd0);
        repeat (3) @(negedge clk);
        check_val("rst stays idle", 32'(bus0.busy), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        bus0.start = 1'b0;
        bus0.abort = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset busy", 32'(bus0.busy), 32'd0);
        check_val("reset stim", 32'(bus0.stim_out), 32'd0);
        check_val("reset err_count", 32'(bus0.err_count), 32'd0);
        check_val("reset pass", 32'(bus0.pass), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // golden circuit
        cur_mode = 0;
        do_run("golden", -1, 1'b0);

        // result bit 4 stuck at 0: only 0xFF fails
        cur_mode = 1; stuck_bit = 4; stuck_val = 1'b0;
        do_run("bit4_sa0", -1, 1'b0);

        // result bit 0 stuck at 1: every pattern with p[1:0] != 2'b11 fails
        cur_mode = 1; stuck_bit = 0; stuck_val = 1'b1;
        do_run("bit0_sa1", -1, 1'b0);

        // two-stage registered circuit: too slow for one settle cycle, fine for two
        cur_mode = 2;
        do_run("pipe2", -1, 1'b1);

        // abort at cycle 100, then a clean full run
        cur_mode = 0;
        do_abort(100);
        do_run("after_abort", -1, 1'b0);

        // synchronous reset in the middle of a run
        do_reset_mid(300);

        // start while busy, and start during DONE, are ignored
        do_run("start_busy", 50, 1'b0);
        do_run("start_done", 768, 1'b0);

        // randomized circuit faults and stray start pulses
        for (int r = 0; r < 4; r++) begin
            cur_mode  = int'($urandom_range(0, 1));
            stuck_bit = int'($urandom_range(0, 4));
            stuck_val = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 5)) @(negedge clk);
            do_run("random", int'($urandom_range(0, 768)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/and_pattern_checker.md
# and_pattern_checker

Exhaustive self-test sequencer for the 4×2-input + 1×8-input AND circuit. The checker drives all 256 input patterns onto the circuit's 8 inputs and samples the circuit's 5 result bits. It compares each result against an internal reference and reports a pass/fail verdict, an error count and the first failing pattern. It sits on the opposite side of the AND circuit's pin interface: its `stim_out` feeds the circuit's `ui_in`, and the circuit's `uo_out[4:0]` feeds `resp_in`.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles between driving a pattern and sampling its response. Legal range 1..15.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  run request; accepted only in IDLE
- `abort`  in  1  cancels a run in progress; ignored in IDLE
- `resp_in`  in  5  circuit results: [3:0] pairwise ANDs, [4] 8-input AND
- `stim_out`  out  8  registered pattern driven to the circuit inputs
- `busy`  out  1  high while a run is active
- `done`  out  1  one-cycle pulse when a run completes
- `pass`  out  1  high after a completed run with zero errors
- `err_count`  out  9  number of mismatching patterns (0..256)
- `first_err_valid`  out  1  high once a mismatch has been recorded
- `first_err_pattern`  out  8  pattern of the first mismatch

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - If `start`=1, go to SETTLE.
  - On that transition: pattern=0, `stim_out`=0, settle counter=0; clear `pass`, `err_count`, `first_err_valid` and `first_err_pattern`.
- SETTLE: increment the counter. After `SETTLE_CYCLES` cycles in SETTLE, go to SAMPLE.
- SAMPLE (one cycle):
  - Compute expected = {&p, p[7]&p[6], p[5]&p[4], p[3]&p[2], p[1]&p[0]}.
  - If `resp_in` != expected: `err_count`+=1.
  - If `first_err_valid`=0 on a mismatch: latch the pattern and set `first_err_valid`.
  - If p==255, go to DONE. Otherwise p+=1, `stim_out` updates, and the state returns to SETTLE.
- DONE (one cycle): `done`=1; `pass`=(`err_count`==0); next state is IDLE.
- `err_count` cannot overflow, because 9 bits hold 256. Pattern increment never wraps, because 255 exits to DONE.
- `abort` while busy:
  - Next state is IDLE and `stim_out`=0.
  - No `done` pulse is generated, and `pass` stays 0.
  - `err_count` and the `first_err_*` outputs keep their partial values.
- `abort` has priority over the SAMPLE and DONE transitions in the same cycle. An abort during DONE still produces the `done` pulse, because DONE has already been reached.
- `start` in any state other than IDLE is ignored, including `start` during DONE.
- `start` and `abort` together in IDLE: the run starts.
- `stim_out` is 0 in IDLE. It is never driven by combinational logic.

## Timing
- Reset values: `stim_out`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_err_valid`=0, `first_err_pattern`=0. State is IDLE.
- Reset asserted mid-run forces all of these values at the next edge.
- `busy` rises one cycle after `start` is sampled. It falls in the cycle after DONE, or one cycle after `abort`.
- Each pattern takes `SETTLE_CYCLES`+1 cycles.
- `done` asserts 256×(`SETTLE_CYCLES`+1)+1 cycles after the `start` edge. With the default, that is 769.
- A circuit response with a pipeline latency L ≤ `SETTLE_CYCLES` is sampled correctly.
- All outputs are registered.

## Structure
- Shared package `and_circuit_pkg` holds:
  - `PAT_W`=8 and `RESP_W`=5
  - state enum `chk_state_t`
  - function `and_expected(pattern)` returning the 5-bit reference result. The AND circuit's own testbench reuses this function.
- One sub-module: `settle_timer`, a loadable down-counter with a `expired` flag.
- The top level contains the FSM, pattern register and error bookkeeping.

## Test plan
- Golden combinational AND model, default parameter, `start` pulse → `done` at cycle 769, `pass`=1, `err_count`=0, `first_err_valid`=0.
- Response bit 4 stuck at 0 → `err_count`=1, `first_err_pattern`=0xFF, `pass`=0.
- Response bit 0 stuck at 1 → `err_count`=192, `first_err_pattern`=0x00, `pass`=0.
- Two-stage-registered circuit model:
  - with `SETTLE_CYCLES`=1 → `err_count`>0
  - with `SETTLE_CYCLES`=2 → `pass`=1
- `abort` at cycle 100 → `busy`=0 and `stim_out`=0 next cycle, no `done` pulse. A following `start` yields a clean full run with `pass`=1.
- `rst` at cycle 300 mid-run → all outputs at reset values next cycle. `start` pulsed while busy → ignored, with the run length unchanged.
